// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Fetch/execute control FSM for the minicpu. Drives the external PC counter
// (which has no hold input, so holding is done by reloading pc), runs the
// instruction-memory fetch handshake and issues instructions to execute.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             begin/resume execution, sampled in IDLE/HALT
//   pc                current PC from the counter
//   pc_ld_n, pc_in    counter control: 0 = load pc_in, 1 = increment
//   imem_req/addr     fetch request and address (addr == pc)
//   imem_ack/data     fetch complete and fetched instruction
//   ir, ir_valid      instruction register and one-cycle issue strobe
//   exec_done         execute finished; jmp_taken/jmp_addr/halt_req qualify it
//   halted            FSM is in HALT
//   retired           completed-instruction count, wraps modulo 2^WIDTH
//
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | imem_req high, waiting for imem_ack
// ISSUE | ir_valid pulse to execute
// EXEC  | waiting for exec_done
// HALT  | stopped by halt_req, waiting for start

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fetch_sequencer #(
   parameter int WIDTH = `DATA_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pc,
   output logic             pc_ld_n,
   output logic [WIDTH-1:0] pc_in,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_data,
   output logic [WIDTH-1:0] ir,
   output logic             ir_valid,
   input  logic             exec_done,
   input  logic             jmp_taken,
   input  logic [WIDTH-1:0] jmp_addr,
   input  logic             halt_req,
   output logic             halted,
   output logic [WIDTH-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ir_q;
   logic [WIDTH-1:0] retired_q;
   logic             imem_req_q;
   logic             ir_valid_q;
   logic             halted_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: if (imem_ack) state_d = S_ISSUE;
         S_ISSUE: state_d = S_EXEC;
         S_EXEC:  if (exec_done) state_d = halt_req ? S_HALT : S_FETCH;
         S_HALT:  if (start) state_d = S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up
   // exactly with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ir_q       <= '0;
         retired_q  <= '0;
         imem_req_q <= 1'b0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         imem_req_q <= (state_d == S_FETCH);
         ir_valid_q <= (state_d == S_ISSUE);
         halted_q   <= (state_d == S_HALT);
         if (state_q == S_FETCH && imem_ack)
            ir_q <= imem_data;
         if (state_q == S_EXEC && exec_done)
            retired_q <= retired_q + WIDTH'(1);
      end
   end

   // Default action is HOLD: reload the counter with its own value.
   always_comb begin
      pc_ld_n = 1'b0;
      pc_in   = pc;
      if (state_q == S_FETCH && imem_ack)
         pc_ld_n = 1'b1;
      else if (state_q == S_EXEC && exec_done && jmp_taken)
         pc_in = jmp_addr;
   end

   assign imem_addr = pc;
   assign imem_req  = imem_req_q;
   assign ir_valid  = ir_valid_q;
   assign halted    = halted_q;
   assign ir        = ir_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer with WIDTH = 8. Models the external PC counter
// and checks the sequencer against a transaction-level reference.

module tb_fetch_sequencer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] pc = '0;
   logic         pc_ld_n;
   logic [W-1:0] pc_in;
   logic         imem_req;
   logic [W-1:0] imem_addr;
   logic         imem_ack = 1'b0;
   logic [W-1:0] imem_data = '0;
   logic [W-1:0] ir;
   logic         ir_valid;
   logic         exec_done = 1'b0;
   logic         jmp_taken = 1'b0;
   logic [W-1:0] jmp_addr = '0;
   logic         halt_req = 1'b0;
   logic         halted;
   logic [W-1:0] retired;

   logic         pc_force = 1'b0;
   logic [W-1:0] pc_force_val = '0;

   int checks = 0;
   int failures = 0;

   fetch_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pc        (pc),
      .pc_ld_n   (pc_ld_n),
      .pc_in     (pc_in),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .ir        (ir),
      .ir_valid  (ir_valid),
      .exec_done (exec_done),
      .jmp_taken (jmp_taken),
      .jmp_addr  (jmp_addr),
      .halt_req  (halt_req),
      .halted    (halted),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   // External PC counter: load when pc_ld_n = 0, else increment.
   always @(posedge clk) begin
      if (pc_force)      pc <= pc_force_val;
      else if (!pc_ld_n) pc <= pc_in;
      else               pc <= pc + 8'd1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      start = 1'b0; imem_ack = 1'b0; imem_data = '0;
      exec_done = 1'b0; jmp_taken = 1'b0; halt_req = 1'b0; jmp_addr = '0;
   endtask

   // Starting in a FETCH cycle: ack next cycle, then advance to EXEC.
   task automatic fetch_to_exec(input logic [W-1:0] d);
      @(negedge clk); imem_ack = 1'b1; imem_data = d;
      @(negedge clk); idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_imem_req got=%0b exp=0", imem_req); end
      reset = 1'b0;
      @(negedge clk); #1;
      checks++; if (ir !== 8'h00) begin failures++; $display("FAIL rst_ir got=%h exp=00", ir); end
      checks++; if (retired !== 8'h00) begin failures++; $display("FAIL rst_retired got=%h exp=00", retired); end
      checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rst_ir_valid got=%0b exp=0", ir_valid); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%0b exp=0", halted); end
      checks++; if (pc_ld_n !== 1'b0) begin failures++; $display("FAIL rst_pc_ld_n got=%0b exp=0", pc_ld_n); end
      checks++; if (pc_in !== pc) begin failures++; $display("FAIL rst_pc_in got=%h exp=%h", pc_in, pc); end
   endtask

   task automatic test_first_fetch();
      @(negedge clk); pc_force = 1'b1; pc_force_val = 8'h00;
      @(negedge clk); pc_force = 1'b0; start = 1'b1; #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ff_req_idle got=%0b exp=0", imem_req); end
      checks++; if (pc_ld_n !== 1'b0) begin failures++; $display("FAIL ff_ld_idle got=%0b exp=0", pc_ld_n); end
      @(negedge clk); start = 1'b0; imem_ack = 1'b1; imem_data = 8'hA5; #1;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL ff_req got=%0b exp=1", imem_req); end
      checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL ff_addr got=%h exp=00", imem_addr); end
      checks++; if (pc_ld_n !== 1'b1) begin failures++; $display("FAIL ff_ld_ack got=%0b exp=1", pc_ld_n); end
      @(negedge clk); idle_inputs(); #1;
      checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL ff_ir_valid got=%0b exp=1", ir_valid); end
      checks++; if (ir !== 8'hA5) begin failures++; $display("FAIL ff_ir got=%h exp=a5", ir); end
      checks++; if (pc !== 8'h01) begin failures++; $display("FAIL ff_pc got=%h exp=01", pc); end
      checks++; if (pc_ld_n !== 1'b0) begin failures++; $display("FAIL ff_ld_issue got=%0b exp=0", pc_ld_n); end
      @(negedge clk); #1;
      checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL ff_ir_valid_exec got=%0b exp=0", ir_valid); end
   endtask

   task automatic test_stall();
      @(negedge clk); pc_force = 1'b1; pc_force_val = 8'h03;
      @(negedge clk); pc_force = 1'b0; exec_done = 1'b1;
      @(negedge clk); idle_inputs();
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stall_req[%0d] got=%0b exp=1", k, imem_req); end
         checks++; if (imem_addr !== 8'h03) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=03", k, imem_addr); end
         checks++; if (pc_ld_n !== 1'b0) begin failures++; $display("FAIL stall_ld[%0d] got=%0b exp=0", k, pc_ld_n); end
         checks++; if (pc_in !== 8'h03) begin failures++; $display("FAIL stall_pc_in[%0d] got=%h exp=03", k, pc_in); end
         checks++; if (pc !== 8'h03) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=03", k, pc); end
      end
      fetch_to_exec(8'h3C);
      #1;
      checks++; if (ir !== 8'h3C) begin failures++; $display("FAIL stall_ir got=%h exp=3c", ir); end
   endtask

   task automatic test_jump();
      logic [W-1:0] r0;
      r0 = retired;
      @(negedge clk); exec_done = 1'b1; jmp_taken = 1'b1; jmp_addr = 8'h40; #1;
      checks++; if (pc_ld_n !== 1'b0) begin failures++; $display("FAIL jmp_ld got=%0b exp=0", pc_ld_n); end
      checks++; if (pc_in !== 8'h40) begin failures++; $display("FAIL jmp_pc_in got=%h exp=40", pc_in); end
      @(negedge clk); idle_inputs(); #1;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL jmp_req got=%0b exp=1", imem_req); end
      checks++; if (imem_addr !== 8'h40) begin failures++; $display("FAIL jmp_addr got=%h exp=40", imem_addr); end
      checks++; if (retired !== r0 + 8'd1) begin failures++; $display("FAIL jmp_retired got=%h exp=%h", retired, r0 + 8'd1); end
      fetch_to_exec(8'h77);
   endtask

   task automatic test_halt_jump();
      @(negedge clk); exec_done = 1'b1; jmp_taken = 1'b1; halt_req = 1'b1; jmp_addr = 8'h10; #1;
      checks++; if (pc_in !== 8'h10) begin failures++; $display("FAIL hj_pc_in got=%h exp=10", pc_in); end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); idle_inputs(); #1;
         checks++; if (halted !== 1'b1) begin failures++; $display("FAIL hj_halted[%0d] got=%0b exp=1", k, halted); end
         checks++; if (pc !== 8'h10) begin failures++; $display("FAIL hj_pc[%0d] got=%h exp=10", k, pc); end
      end
      @(negedge clk); start = 1'b1; #1;
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL hj_halted_start got=%0b exp=1", halted); end
      @(negedge clk); start = 1'b0; #1;
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL hj_resume_halted got=%0b exp=0", halted); end
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL hj_resume_req got=%0b exp=1", imem_req); end
      checks++; if (imem_addr !== 8'h10) begin failures++; $display("FAIL hj_resume_addr got=%h exp=10", imem_addr); end
      fetch_to_exec(8'h99);
   endtask

   task automatic test_reset_mid_fetch();
      logic [W-1:0] p0;
      @(negedge clk); exec_done = 1'b1;
      @(negedge clk); idle_inputs(); #1;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rmf_pre_req got=%0b exp=1", imem_req); end
      p0 = pc;
      #2 reset = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rmf_req got=%0b exp=0", imem_req); end
      checks++; if (ir !== 8'h00) begin failures++; $display("FAIL rmf_ir got=%h exp=00", ir); end
      checks++; if (retired !== 8'h00) begin failures++; $display("FAIL rmf_retired got=%h exp=00", retired); end
      checks++; if (pc_ld_n !== 1'b0) begin failures++; $display("FAIL rmf_ld got=%0b exp=0", pc_ld_n); end
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exec_done = 1'b1; imem_ack = 1'b1; imem_data = 8'($urandom);
         jmp_taken = 1'b1; halt_req = 1'($urandom); jmp_addr = 8'($urandom);
         #1;
         checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rmf_stray_req[%0d] got=%0b exp=0", k, imem_req); end
         checks++; if (ir !== 8'h00) begin failures++; $display("FAIL rmf_stray_ir[%0d] got=%h exp=00", k, ir); end
         checks++; if (retired !== 8'h00) begin failures++; $display("FAIL rmf_stray_ret[%0d] got=%h exp=00", k, retired); end
         checks++; if (pc !== p0) begin failures++; $display("FAIL rmf_stray_pc[%0d] got=%h exp=%h", k, pc, p0); end
         checks++; if (pc_ld_n !== 1'b0) begin failures++; $display("FAIL rmf_stray_ld[%0d] got=%0b exp=0", k, pc_ld_n); end
      end
      @(negedge clk); idle_inputs();
   endtask

   // Random instruction stream with stalls, jumps, halts and stray inputs,
   // checked against a transaction model: expected pc, ir, retire count.
   task automatic test_random();
      localparam int N = 300;
      logic [W-1:0] exp_pc, exp_ir, d, ja;
      int n_retired, pulses, w;
      bit j, h;
      exp_pc = 8'($urandom);
      exp_ir = 8'h00;
      n_retired = 0;
      pulses = 0;
      @(negedge clk); pc_force = 1'b1; pc_force_val = exp_pc;
      @(negedge clk); pc_force = 1'b0; start = 1'b1;
      for (int i = 0; i < N; i++) begin
         w = $urandom_range(0, 3);
         for (int k = 0; k < w; k++) begin
            @(negedge clk); idle_inputs();
            exec_done = 1'($urandom); start = 1'($urandom); #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc_ld_n !== 1'b0 || ir_valid !== 1'b0)
               begin failures++; $display("FAIL rnd_fetch_wait[%0d] req=%0b addr=%h ld=%0b v=%0b exp req=1 addr=%h ld=0 v=0", i, imem_req, imem_addr, pc_ld_n, ir_valid, exp_pc); end
            checks++; if (retired !== 8'(n_retired) || halted !== 1'b0)
               begin failures++; $display("FAIL rnd_retired[%0d] got=%h halted=%0b exp=%h halted=0", i, retired, halted, 8'(n_retired)); end
         end
         d = 8'($urandom);
         @(negedge clk); idle_inputs(); imem_ack = 1'b1; imem_data = d; exec_done = 1'($urandom); #1;
         checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc_ld_n !== 1'b1)
            begin failures++; $display("FAIL rnd_ack[%0d] req=%0b addr=%h ld=%0b exp req=1 addr=%h ld=1", i, imem_req, imem_addr, pc_ld_n, exp_pc); end
         exp_pc = exp_pc + 8'd1;
         exp_ir = d;
         @(negedge clk); idle_inputs(); imem_ack = 1'($urandom); imem_data = 8'($urandom); #1;
         if (ir_valid === 1'b1) pulses++;
         checks++; if (ir_valid !== 1'b1 || ir !== exp_ir || imem_req !== 1'b0)
            begin failures++; $display("FAIL rnd_issue[%0d] v=%0b ir=%h req=%0b exp v=1 ir=%h req=0", i, ir_valid, ir, imem_req, exp_ir); end
         w = $urandom_range(0, 3);
         for (int k = 0; k < w; k++) begin
            @(negedge clk); idle_inputs();
            jmp_taken = 1'($urandom); halt_req = 1'($urandom); jmp_addr = 8'($urandom);
            imem_ack = 1'($urandom); imem_data = 8'($urandom); start = 1'($urandom); #1;
            checks++; if (ir_valid !== 1'b0 || ir !== exp_ir || imem_req !== 1'b0 || pc !== exp_pc || pc_ld_n !== 1'b0 || pc_in !== exp_pc)
               begin failures++; $display("FAIL rnd_exec_wait[%0d] v=%0b ir=%h req=%0b pc=%h ld=%0b pc_in=%h exp ir=%h pc=%h", i, ir_valid, ir, imem_req, pc, pc_ld_n, pc_in, exp_ir, exp_pc); end
         end
         j = ($urandom_range(0, 3) == 0);
         h = ($urandom_range(0, 7) == 0);
         ja = 8'($urandom);
         @(negedge clk); idle_inputs(); exec_done = 1'b1; jmp_taken = j; halt_req = h; jmp_addr = ja; #1;
         checks++; if (pc_ld_n !== 1'b0 || pc_in !== (j ? ja : exp_pc))
            begin failures++; $display("FAIL rnd_done[%0d] ld=%0b pc_in=%h exp ld=0 pc_in=%h", i, pc_ld_n, pc_in, j ? ja : exp_pc); end
         n_retired++;
         if (j) exp_pc = ja;
         if (h) begin
            w = $urandom_range(1, 3);
            for (int k = 0; k < w; k++) begin
               @(negedge clk); idle_inputs(); #1;
               checks++; if (halted !== 1'b1 || pc !== exp_pc || imem_req !== 1'b0)
                  begin failures++; $display("FAIL rnd_halt[%0d] halted=%0b pc=%h req=%0b exp halted=1 pc=%h req=0", i, halted, pc, imem_req, exp_pc); end
            end
            @(negedge clk); idle_inputs(); start = 1'b1; #1;
            checks++; if (halted !== 1'b1 || retired !== 8'(n_retired))
               begin failures++; $display("FAIL rnd_halt_start[%0d] halted=%0b ret=%h exp halted=1 ret=%h", i, halted, retired, 8'(n_retired)); end
         end
      end
      @(negedge clk); idle_inputs(); #1;
      checks++; if (retired !== 8'(N)) begin failures++; $display("FAIL rnd_final_retired got=%h exp=%h", retired, 8'(N)); end
      checks++; if (pulses != N) begin failures++; $display("FAIL rnd_pulses got=%0d exp=%0d", pulses, N); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_stall();
      test_jump();
      test_halt_jump();
      test_reset_mid_fetch();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
